song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter: BEAT_TICKS, default 25_000_000, clock cycles per note step (0.25 s at 100 MHz).
REQ-002 Parameter: GAP_TICKS, default 2_500_000, silent cycles at the end of each step so repeated notes articulate.
REQ-003 Parameter: SONG_LEN, default 31, number of note entries played (1..256).
REQ-004 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port: rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-006 Port: start  input  1  single-cycle pulse; begin play, restart, or resume.
REQ-007 Port: pause  input  1  single-cycle pulse; toggles pause while playing.
REQ-008 Port: stop  input  1  single-cycle pulse; abort and return to idle.
REQ-009 Port: mem_index  output  8  address to the song note memory; registered.
REQ-010 Port: mem_note  input  10  one-hot note read combinationally from the memory at mem_index.
REQ-011 Port: note_out  output  10  one-hot note to the tone generator; all-zero means silence; registered.
REQ-012 Port: playing  output  1  high in PLAY or GAP.
REQ-013 Port: beat_pulse  output  1  one-cycle strobe on every index advance.
REQ-014 Port: done  output  1  high while in DONE.

Function
REQ-015 States: IDLE, PLAY, GAP, PAUSED, DONE; one-hot or binary encoding is free.
REQ-016 Input priority in the same cycle: stop > start > pause.
REQ-017 IDLE: mem_index=0, note_out=0, tick counter=0; start -> PLAY with mem_index=0.
REQ-018 PLAY: note_out <= mem_note every cycle, giving one-cycle latency from mem_index change to note_out.
REQ-019 PLAY lasts exactly BEAT_TICKS-GAP_TICKS cycles, then -> GAP with the counter cleared.
REQ-020 GAP: note_out=0; lasts exactly GAP_TICKS cycles; if GAP_TICKS=0, GAP is skipped entirely.
REQ-021 End of step, index < SONG_LEN-1: mem_index+1, -> PLAY, beat_pulse=1 for that one cycle.
REQ-022 End of step, index = SONG_LEN-1: -> DONE, mem_index held, note_out=0, no beat_pulse.
REQ-023 A full step is therefore BEAT_TICKS cycles.
REQ-024 pause in PLAY or GAP: -> PAUSED; save the return state; freeze counter and mem_index; note_out=0.
REQ-025 pause or start in PAUSED: resume the saved state with the counter continuing from its frozen value.
REQ-026 Resume into PLAY reloads note_out from mem_note on the next edge.
REQ-027 stop in any state: -> IDLE next edge, mem_index=0, note_out=0, counter=0.
REQ-028 start in PLAY or GAP: restart from index 0 in PLAY with the counter cleared.
REQ-029 start in DONE: restart from index 0; pause is ignored in IDLE and DONE.
REQ-030 Counter width is ceil(log2(BEAT_TICKS)); counter never exceeds BEAT_TICKS-1; mem_index never exceeds SONG_LEN-1.
REQ-031 Parameters satisfy GAP_TICKS < BEAT_TICKS, enforced by an elaboration-time check.

Reset
REQ-032 rst_n low asynchronously forces IDLE: mem_index=0, note_out=0, playing=0, beat_pulse=0, done=0, counter=0, saved state=PLAY.
REQ-033 Reset asserted mid-song aborts immediately; after release, the block waits in IDLE for start.

Verification (BEAT_TICKS=8, GAP_TICKS=2, SONG_LEN=4, memory model returns 10'b1<<index)
REQ-034 Start pulse at cycle 0 -> mem_index=0 at edge 1; note_out=10'h001 from edge 2 for 5 cycles, then 0 for 2 cycles; beat_pulse and mem_index=1 at edge 9; steps repeat every 8 cycles.
REQ-035 Full run -> exactly 3 beat_pulses; DONE entered 32 cycles after start with mem_index=3, done=1, playing=0, note_out=0.
REQ-036 Pause at step 1, tick 3 -> note_out=0 and counter frozen for 20 cycles; pause again -> note_out=10'h002 again one cycle later; remaining step time is exactly 5 cycles (3 PLAY, 2 GAP).
REQ-037 Stop and start asserted in the same cycle during step 2 -> IDLE with mem_index=0 and no restart; a later start plays from index 0.
REQ-038 rst_n low for 1 cycle during a GAP at step 2 -> all outputs 0 immediately (asynchronously); no beat_pulse afterwards until a new start.
REQ-039 GAP_TICKS=0 rerun -> note_out never returns to 0 between steps; mem_index advances every 8 cycles.

Source files
------------

// File: rtl/song_sequencer_if.sv
// Control, memory and status signals between a song sequencer and the logic driving it.
interface song_sequencer_if;
  logic       start;
  logic       pause;
  logic       stop;
  logic [7:0] mem_index;
  logic [9:0] mem_note;
  logic [9:0] note_out;
  logic       playing;
  logic       beat_pulse;
  logic       done;

  modport master (
    output start, pause, stop, mem_note,
    input  mem_index, note_out, playing, beat_pulse, done
  );

  modport slave (
    input  start, pause, stop, mem_note,
    output mem_index, note_out, playing, beat_pulse, done
  );
endinterface

// File: rtl/song_sequencer.sv
// Steps through a note memory, one note per BEAT_TICKS cycles with a trailing silent gap,
// with start/restart, pause/resume and stop controls.
module song_sequencer #(
  parameter int BEAT_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 2_500_000,
  parameter int SONG_LEN   = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  song_sequencer_if.slave   sq
);
  localparam int CW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [CW-1:0] PLAY_LAST = CW'(BEAT_TICKS - GAP_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [7:0]    LAST_IDX  = 8'(SONG_LEN - 1);

  if (GAP_TICKS >= BEAT_TICKS || GAP_TICKS < 0 || SONG_LEN < 1 || SONG_LEN > 256) begin : g_bad_params
    $error("song_sequencer: require 0 <= GAP_TICKS < BEAT_TICKS and 1 <= SONG_LEN <= 256");
  end

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_GAP, S_PAUSED, S_DONE} state_e;

  state_e        state_q, state_d, ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    idx_q, idx_d;
  logic [9:0]    note_q, note_d;
  logic          beat_q, beat_d;
  logic          step_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ret_q   <= S_PLAY;
      cnt_q   <= '0;
      idx_q   <= '0;
      note_q  <= '0;
      beat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    note_d   = note_q;
    beat_d   = 1'b0;
    step_end = 1'b0;
    if (sq.stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      note_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          note_d = '0;
          if (sq.start) begin
            state_d = S_PLAY;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        S_PLAY: begin
          if (sq.start) begin
            state_d = S_PLAY;
            cnt_d   = '0;
            idx_d   = '0;
            note_d  = '0;
          end else if (sq.pause) begin
            state_d = S_PAUSED;
            ret_d   = S_PLAY;
            note_d  = '0;
          end else begin
            note_d = sq.mem_note;
            if (cnt_q == PLAY_LAST) begin
              cnt_d = '0;
              // With no gap the step ends here and the note keeps sounding into the next one
              if (GAP_TICKS != 0) begin
                state_d = S_GAP;
                note_d  = '0;
              end else begin
                step_end = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          note_d = '0;
          if (sq.start) begin
            state_d = S_PLAY;
            cnt_d   = '0;
            idx_d   = '0;
          end else if (sq.pause) begin
            state_d = S_PAUSED;
            ret_d   = S_GAP;
          end else if (cnt_q == GAP_LAST) begin
            cnt_d    = '0;
            step_end = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PAUSED: begin
          note_d = '0;
          if (sq.start || sq.pause) state_d = ret_q;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          note_d  = '0;
        end
      endcase

      if (step_end) begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          note_d  = '0;
        end else begin
          state_d = S_PLAY;
          idx_d   = idx_q + 8'd1;
          beat_d  = 1'b1;
        end
      end
    end
  end

  assign sq.mem_index  = idx_q;
  assign sq.note_out   = note_q;
  assign sq.beat_pulse = beat_q;
  assign sq.playing    = (state_q == S_PLAY) || (state_q == S_GAP);
  assign sq.done       = (state_q == S_DONE);
endmodule

// File: tb/tb_song_sequencer.sv
// Directed checks of the song sequencer with an 8-cycle step, 2-cycle gap and 4-note song,
// plus a gapless instance.
module tb_song_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   beats;

  always #5 clk = ~clk;

  song_sequencer_if sif();
  song_sequencer_if gif();
  assign sif.mem_note = 10'd1 << sif.mem_index;
  assign gif.mem_note = 10'd1 << gif.mem_index;

  song_sequencer #(.BEAT_TICKS(8), .GAP_TICKS(2), .SONG_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .sq(sif.slave));
  song_sequencer #(.BEAT_TICKS(8), .GAP_TICKS(0), .SONG_LEN(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .sq(gif.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: sif.start = 1'b1;
      1: sif.pause = 1'b1;
      default: sif.stop = 1'b1;
    endcase
    tick();
    sif.start = 1'b0; sif.pause = 1'b0; sif.stop = 1'b0;
  endtask

  initial begin
    sif.start = 1'b0; sif.pause = 1'b0; sif.stop = 1'b0;
    gif.start = 1'b0; gif.pause = 1'b0; gif.stop = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst idx",     32'(sif.mem_index),  0);
    chk("rst note",    32'(sif.note_out),   0);
    chk("rst playing", 32'(sif.playing),    0);
    chk("rst beat",    32'(sif.beat_pulse), 0);
    chk("rst done",    32'(sif.done),       0);
    rst_n = 1'b1;
    tick();

    // pause is ignored in IDLE
    pulse(1);
    chk("idle pause playing", 32'(sif.playing), 0);

    // full run: edge 1 is the start edge
    pulse(0);
    chk("run e1 idx",     32'(sif.mem_index), 0);
    chk("run e1 playing", 32'(sif.playing),   1);
    chk("run e1 note",    32'(sif.note_out),  0);
    beats = 0;
    for (int e = 2; e <= 33; e++) begin
      tick();
      if (sif.beat_pulse) beats++;
      if (e <= 6)              chk("run step0 note", 32'(sif.note_out), 32'h001);
      if (e == 7 || e == 8)    chk("run gap0 note",  32'(sif.note_out), 0);
      if (e == 8)              chk("run e8 beat",    32'(sif.beat_pulse), 0);
      if (e == 9) begin
        chk("run e9 beat", 32'(sif.beat_pulse), 1);
        chk("run e9 idx",  32'(sif.mem_index),  1);
      end
      if (e == 10) begin
        chk("run e10 note", 32'(sif.note_out),   32'h002);
        chk("run e10 beat", 32'(sif.beat_pulse), 0);
      end
      if (e == 32) chk("run e32 done", 32'(sif.done), 0);
    end
    chk("run beats",        32'(beats),          3);
    chk("run done",         32'(sif.done),       1);
    chk("run done idx",     32'(sif.mem_index),  3);
    chk("run done playing", 32'(sif.playing),    0);
    chk("run done note",    32'(sif.note_out),   0);

    pulse(1);
    chk("done pause ignored", 32'(sif.done), 1);
    pulse(0);
    chk("done restart idx",     32'(sif.mem_index), 0);
    chk("done restart playing", 32'(sif.playing),   1);
    pulse(2);
    chk("stop idx",     32'(sif.mem_index), 0);
    chk("stop playing", 32'(sif.playing),   0);

    // pause at step 1 tick 3, hold 20 cycles, resume
    pulse(0);
    repeat (11) tick();
    chk("pz e12 note", 32'(sif.note_out), 32'h002);
    pulse(1);
    chk("pz note",    32'(sif.note_out), 0);
    chk("pz playing", 32'(sif.playing),  0);
    beats = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (sif.beat_pulse || sif.note_out != 0 || sif.mem_index != 1) beats++;
    end
    chk("pz frozen", 32'(beats), 0);
    pulse(1);
    chk("pz resume note",    32'(sif.note_out), 0);
    chk("pz resume playing", 32'(sif.playing),  1);
    tick(); chk("pz r+1 note", 32'(sif.note_out), 32'h002);
    tick(); chk("pz r+2 note", 32'(sif.note_out), 32'h002);
    tick(); chk("pz r+3 note", 32'(sif.note_out), 0);
    tick(); chk("pz r+4 beat", 32'(sif.beat_pulse), 0);
    chk("pz r+4 idx", 32'(sif.mem_index), 1);
    tick(); chk("pz r+5 beat", 32'(sif.beat_pulse), 1);
    chk("pz r+5 idx", 32'(sif.mem_index), 2);
    pulse(2);

    // stop and start together in step 2: stop wins
    pulse(0);
    repeat (18) tick();
    chk("ss e19 idx", 32'(sif.mem_index), 2);
    sif.start = 1'b1; sif.stop = 1'b1;
    tick();
    sif.start = 1'b0; sif.stop = 1'b0;
    chk("ss idx",     32'(sif.mem_index), 0);
    chk("ss playing", 32'(sif.playing),   0);
    chk("ss note",    32'(sif.note_out),  0);
    repeat (5) tick();
    chk("ss still idle", 32'(sif.playing), 0);
    pulse(0);
    chk("ss restart idx", 32'(sif.mem_index), 0);
    tick();
    chk("ss restart note", 32'(sif.note_out), 32'h001);

    // start while playing step 1 restarts from index 0
    repeat (10) tick();
    chk("rs pre idx", 32'(sif.mem_index), 1);
    pulse(0);
    chk("rs idx",     32'(sif.mem_index), 0);
    chk("rs playing", 32'(sif.playing),   1);
    tick();
    chk("rs note", 32'(sif.note_out), 32'h001);
    pulse(2);

    // asynchronous reset during the step-2 gap
    pulse(0);
    repeat (22) tick();
    chk("ar gap idx",  32'(sif.mem_index), 2);
    chk("ar gap note", 32'(sif.note_out),  0);
    rst_n = 1'b0;
    #1;
    chk("ar idx",     32'(sif.mem_index), 0);
    chk("ar playing", 32'(sif.playing),   0);
    chk("ar done",    32'(sif.done),      0);
    chk("ar beat",    32'(sif.beat_pulse), 0);
    tick();
    rst_n = 1'b1;
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sif.beat_pulse || sif.playing) beats++;
    end
    chk("ar stays idle", 32'(beats), 0);

    // gapless instance: note never drops between steps
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    beats = 0;
    for (int e = 2; e <= 33; e++) begin
      tick();
      if (gif.beat_pulse) beats++;
      if (e <= 32) chk("g0 note", 32'(gif.note_out), 32'(1 << ((e - 2) / 8)));
      if (e == 9 || e == 17 || e == 25) chk("g0 idx", 32'(gif.mem_index), 32'((e - 1) / 8));
    end
    chk("g0 beats",     32'(beats),         3);
    chk("g0 done",      32'(gif.done),      1);
    chk("g0 done note", 32'(gif.note_out),  0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
